yd_dbus_periph: RTL and testbench

//  Data-bus endpoint downstream of the Yduck core dbus. Decodes core d_addr into an external

---
 rtl/yd_dbus_periph.sv | 196 +++++++++++++++++++
 tb/tb_yd_dbus_periph.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yd_dbus_periph.sv
// rtl/yd_dbus_periph.sv - Yduck dbus endpoint: data RAM decode plus GPIO/timer/IRQ peripheral window
//
// Optional feature macro: YD_GPIO_IRQ_EN (GPIO rising-edge interrupt, IRQ_STAT[1] / TMR_CTRL[3])
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   d_addr/d_din/d_we     core data bus request
//   d_dout                read data for the address presented in the previous cycle
//   ram_addr/ram_din/ram_we/ram_dout   external synchronous data RAM (1-cycle read)
//   gpio_out/gpio_in      GPIO output register / asynchronous GPIO inputs
//   int_vld/int_rdy       one-cycle interrupt pulse to the core and its accept qualifier
//
// Register window (offset from PERIPH_BASE):
//   0 GPIO_OUT rw | 1 GPIO_IN ro | 2 TMR_CTRL rw [0]EN [1]CLR_ON_MATCH [2]TIE [3]GIE
//   3 TMR_PRE rw  | 4 TMR_CNT rw | 5 TMR_CMP rw  | 6 IRQ_STAT W1C [0]TMR [1]GPIO

module yd_dbus_periph #(
    parameter logic [15:0] PERIPH_BASE = 16'hFF00,
    parameter int          GPIO_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       d_addr,
    input  logic [15:0]       d_din,
    input  logic              d_we,
    output logic [15:0]       d_dout,
    output logic [15:0]       ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_we,
    input  logic [15:0]       ram_dout,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              int_vld,
    input  logic              int_rdy
);

    localparam logic [15:0] OFF_GPIO_OUT = 16'd0;
    localparam logic [15:0] OFF_GPIO_IN  = 16'd1;
    localparam logic [15:0] OFF_TMR_CTRL = 16'd2;
    localparam logic [15:0] OFF_TMR_PRE  = 16'd3;
    localparam logic [15:0] OFF_TMR_CNT  = 16'd4;
    localparam logic [15:0] OFF_TMR_CMP  = 16'd5;
    localparam logic [15:0] OFF_IRQ_STAT = 16'd6;

    // Address decode
    logic        periph_sel;
    logic [15:0] off;
    logic        wr_en;
    logic        wr_gpio, wr_ctrl, wr_pre, wr_cnt, wr_cmp, wr_stat;

    assign periph_sel = (d_addr >= PERIPH_BASE);
    assign off        = d_addr - PERIPH_BASE;
    assign wr_en      = d_we & periph_sel;
    assign wr_gpio    = wr_en && (off == OFF_GPIO_OUT);
    assign wr_ctrl    = wr_en && (off == OFF_TMR_CTRL);
    assign wr_pre     = wr_en && (off == OFF_TMR_PRE);
    assign wr_cnt     = wr_en && (off == OFF_TMR_CNT);
    assign wr_cmp     = wr_en && (off == OFF_TMR_CMP);
    assign wr_stat    = wr_en && (off == OFF_IRQ_STAT);

    // RAM pass-through; peripheral writes never reach the RAM
    assign ram_addr = d_addr;
    assign ram_din  = d_din;
    assign ram_we   = d_we & ~periph_sel;

    // State
    logic [GPIO_W-1:0] gpio_out_r;
    logic [GPIO_W-1:0] gpio_s1, gpio_s2;
    logic [3:0]        tmr_ctrl;
    logic [15:0]       tmr_pre, tmr_cnt, tmr_cmp;
    logic [15:0]       pre_cnt;
    logic [1:0]        irq_stat;
    logic              sent;
    logic              int_vld_r;
    logic              sel_r;
    logic [15:0]       rdata_r;

    // Two-flop synchroniser; left unreset so it tracks the pins through reset
    always_ff @(posedge clk) begin
        gpio_s1 <= gpio_in;
        gpio_s2 <= gpio_s1;
    end

    logic       gpio_set;
    logic [3:0] ctrl_wdata;

`ifdef YD_GPIO_IRQ_EN
    logic [GPIO_W-1:0] gpio_prev;
    logic              edge_armed;

    // edge_armed masks the first cycle after reset, so inputs that are already
    // high when reset releases are absorbed into gpio_prev without firing
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_prev  <= '0;
            edge_armed <= 1'b0;
        end else begin
            gpio_prev  <= gpio_s2;
            edge_armed <= 1'b1;
        end
    end

    assign gpio_set   = edge_armed & (|(gpio_s2 & ~gpio_prev));
    assign ctrl_wdata = d_din[3:0];
`else
    assign gpio_set   = 1'b0;
    assign ctrl_wdata = {1'b0, d_din[2:0]};
`endif

    // Timer tick/match and interrupt request
    logic tmr_en, tick, match, irq_req;
    logic [1:0] stat_w1c, stat_set;

    assign tmr_en   = tmr_ctrl[0];
    assign tick     = tmr_en && (pre_cnt == tmr_pre);
    assign match    = tick && (tmr_cnt == tmr_cmp);
    assign irq_req  = (irq_stat[0] & tmr_ctrl[2]) | (irq_stat[1] & tmr_ctrl[3]);
    assign stat_w1c = wr_stat ? d_din[1:0] : 2'b00;
    assign stat_set = {gpio_set, match};

    // Read mux, zero-extending the GPIO registers to the bus width
    logic [15:0] gpio_out_ext, gpio_in_ext, rdata_next;

    always_comb begin
        gpio_out_ext              = '0;
        gpio_out_ext[GPIO_W-1:0]  = gpio_out_r;
        gpio_in_ext               = '0;
        gpio_in_ext[GPIO_W-1:0]   = gpio_s2;
        rdata_next                = 16'h0000;
        if (periph_sel) begin
            case (off)
                OFF_GPIO_OUT: rdata_next = gpio_out_ext;
                OFF_GPIO_IN:  rdata_next = gpio_in_ext;
                OFF_TMR_CTRL: rdata_next = {12'h000, tmr_ctrl};
                OFF_TMR_PRE:  rdata_next = tmr_pre;
                OFF_TMR_CNT:  rdata_next = tmr_cnt;
                OFF_TMR_CMP:  rdata_next = tmr_cmp;
                OFF_IRQ_STAT: rdata_next = {14'h0000, irq_stat};
                default:      rdata_next = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_r <= '0;
            tmr_ctrl   <= 4'h0;
            tmr_pre    <= 16'h0000;
            tmr_cnt    <= 16'h0000;
            tmr_cmp    <= 16'h0000;
            pre_cnt    <= 16'h0000;
            irq_stat   <= 2'b00;
            sent       <= 1'b0;
            int_vld_r  <= 1'b0;
            sel_r      <= 1'b0;
            rdata_r    <= 16'h0000;
        end else begin
            sel_r   <= periph_sel;
            rdata_r <= rdata_next;

            if (wr_gpio) gpio_out_r <= d_din[GPIO_W-1:0];
            if (wr_ctrl) tmr_ctrl   <= ctrl_wdata;
            if (wr_cmp)  tmr_cmp    <= d_din;

            // Reloading the period restarts the prescaler so a shorter period
            // never has to wrap the full 16-bit range first
            if (wr_pre) begin
                tmr_pre <= d_din;
                pre_cnt <= 16'h0000;
            end else if (tmr_en) begin
                pre_cnt <= tick ? 16'h0000 : pre_cnt + 16'h0001;
            end

            // CPU write to the counter overrides the tick update
            if (wr_cnt)
                tmr_cnt <= d_din;
            else if (tick)
                tmr_cnt <= (match && tmr_ctrl[1]) ? 16'h0000 : tmr_cnt + 16'h0001;

            // Hardware set wins over a same-cycle W1C
            irq_stat <= (irq_stat & ~stat_w1c) | stat_set;

            // One pulse per request assertion; re-armed only once req drops
            if (!irq_req)
                sent <= 1'b0;
            else if (int_rdy && !sent)
                sent <= 1'b1;
            int_vld_r <= irq_req & ~sent & int_rdy;
        end
    end

    assign gpio_out = gpio_out_r;
    assign int_vld  = int_vld_r;
    assign d_dout   = sel_r ? rdata_r : ram_dout;

endmodule

// File: tb/tb_yd_dbus_periph.sv
// tb/tb_yd_dbus_periph.sv - directed self-checking bench for yd_dbus_periph

module tb_yd_dbus_periph;

`ifdef YD_GPIO_IRQ_EN
    localparam bit GPIO_IRQ = 1'b1;
`else
    localparam bit GPIO_IRQ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] d_addr;
    logic [15:0] d_din;
    logic        d_we;
    logic [15:0] d_dout;
    logic [15:0] ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic [15:0] gpio_out;
    logic [15:0] gpio_in;
    logic        int_vld;
    logic        int_rdy;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;

    yd_dbus_periph #(
        .PERIPH_BASE (16'hFF00),
        .GPIO_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_addr   (d_addr),
        .d_din    (d_din),
        .d_we     (d_we),
        .d_dout   (d_dout),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .int_vld  (int_vld),
        .int_rdy  (int_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: unwritten words read as 0xA000 | addr[7:0]
    logic [15:0]  mem [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[7:0]]     <= ram_din;
            written[ram_addr[7:0]] <= 1'b1;
        end
        ram_dout <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : (16'hA000 | {8'h00, ram_addr[7:0]});
    end

    always @(negedge clk) begin
        if (int_vld === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] v);
        d_addr = a;
        d_din  = v;
        d_we   = 1'b1;
        step();
        d_we   = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [15:0] v);
        d_addr = a;
        d_we   = 1'b0;
        step();
        v = d_dout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int base;

        rst = 1'b1; d_addr = 16'h0000; d_din = 16'h0000; d_we = 1'b0;
        gpio_in = 16'h0000; int_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_int_vld", 16'(int_vld), 16'h0000);
        chk("rst_gpio_out", gpio_out, 16'h0000);
        chk("rst_d_dout_follows_ram", d_dout, 16'hA000);
        bus_rd(16'h0003, v);  chk("rst_ram_read", v, 16'hA003);
        bus_rd(16'hFF02, v);  chk("rst_tmr_ctrl", v, 16'h0000);

        // 1: RAM path
        d_addr = 16'h0010; d_din = 16'h1234; d_we = 1'b1; #1;
        chk("ram_we_on_ram_write", 16'(ram_we), 16'h0001);
        step(); d_we = 1'b0;
        bus_rd(16'h0010, v);  chk("ram_readback", v, 16'h1234);
        chk("ram_no_periph_change", gpio_out, 16'h0000);

        // 2: peripheral read/write
        d_addr = 16'hFF00; d_din = 16'h00A5; d_we = 1'b1; #1;
        chk("ram_we_masked_periph", 16'(ram_we), 16'h0000);
        step(); d_we = 1'b0;
        chk("gpio_out_write", gpio_out, 16'h00A5);
        bus_rd(16'hFF00, v);  chk("gpio_out_read", v, 16'h00A5);
        bus_rd(16'h0010, v);  chk("b2b_periph_then_ram", v, 16'h1234);
        bus_rd(16'hFF07, v);  chk("unmapped_read", v, 16'h0000);
        gpio_in = 16'h5A38;
        step(); step();
        bus_rd(16'hFF01, v);  chk("gpio_in_read", v, 16'h5A38);
        bus_wr(16'hFF01, 16'hFFFF);
        bus_rd(16'hFF01, v);  chk("gpio_in_ro", v, 16'h5A38);
        bus_wr(16'hFF06, 16'h0003);

        // 3: timer PRE=1 CMP=3 CTRL=EN|CLR|TIE, match on 8th enabled cycle
        bus_wr(16'hFF03, 16'h0001);
        bus_wr(16'hFF05, 16'h0003);
        bus_wr(16'hFF04, 16'h0000);
        base = pulse_cnt;
        bus_wr(16'hFF02, 16'h0007);
        repeat (7) step();
        chk("tmr_no_irq_cycle7", 16'(int_vld), 16'h0000);
        step();
        chk("tmr_no_irq_cycle8", 16'(int_vld), 16'h0000);
        bus_rd(16'hFF04, v);  chk("tmr_cnt_cleared", v, 16'h0000);
        chk("tmr_int_pulse", 16'(int_vld), 16'h0001);
        bus_rd(16'hFF06, v);  chk("tmr_stat_set", v, 16'h0001);
        chk("tmr_int_pulse_end", 16'(int_vld), 16'h0000);
        bus_wr(16'hFF02, 16'h0006);
        repeat (3) step();
        chk("tmr_single_pulse", 16'(pulse_cnt - base), 16'h0001);

        // 4: handshake with int_rdy low
        int_rdy = 1'b0;
        bus_wr(16'hFF06, 16'h0001);
        bus_wr(16'hFF04, 16'h0003);
        bus_wr(16'hFF03, 16'h0000);
        bus_wr(16'hFF02, 16'h0007);
        bus_wr(16'hFF02, 16'h0006);
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hs_wait_rdy", 16'(int_vld), 16'h0000);
        end
        int_rdy = 1'b1;
        step();
        chk("hs_pulse_after_rdy", 16'(int_vld), 16'h0001);
        step();
        chk("hs_pulse_one_cycle", 16'(int_vld), 16'h0000);
        repeat (3) step();
        chk("hs_no_second_pulse", 16'(pulse_cnt - base), 16'h0001);
        bus_wr(16'hFF06, 16'h0001);
        bus_rd(16'hFF06, v);  chk("hs_w1c_clears", v, 16'h0000);
        base = pulse_cnt;
        bus_wr(16'hFF04, 16'h0003);
        bus_wr(16'hFF02, 16'h0007);
        bus_wr(16'hFF02, 16'h0006);
        repeat (3) step();
        chk("hs_repulse", 16'(pulse_cnt - base), 16'h0001);

        // 5a: CPU write to CNT on a tick cycle wins
        bus_wr(16'hFF06, 16'h0003);
        bus_wr(16'hFF05, 16'h0050);
        bus_wr(16'hFF03, 16'h0000);
        bus_wr(16'hFF02, 16'h0001);
        bus_wr(16'hFF04, 16'h0100);
        bus_rd(16'hFF04, v);  chk("col_cnt_write_wins", v, 16'h0100);
        bus_wr(16'hFF02, 16'h0000);
        bus_rd(16'hFF04, v);  chk("col_cnt_ticks_every_cycle", v, 16'h0102);

        // 5b: W1C in the same cycle as a hardware set
        bus_wr(16'hFF04, 16'h0005);
        bus_wr(16'hFF05, 16'h0005);
        bus_wr(16'hFF02, 16'h0001);
        bus_wr(16'hFF06, 16'h0001);
        bus_rd(16'hFF06, v);  chk("col_set_beats_w1c", v, 16'h0001);
        bus_wr(16'hFF02, 16'h0000);
        bus_wr(16'hFF06, 16'h0003);
        bus_rd(16'hFF06, v);  chk("col_w1c_after", v, 16'h0000);

        // 5c: 0xFFFF wraps to 0 without flag
        bus_wr(16'hFF04, 16'hFFFF);
        bus_wr(16'hFF05, 16'h0000);
        bus_wr(16'hFF03, 16'h0000);
        bus_wr(16'hFF02, 16'h0001);
        bus_wr(16'hFF02, 16'h0000);
        bus_rd(16'hFF04, v);  chk("wrap_cnt", v, 16'h0000);
        bus_rd(16'hFF06, v);  chk("wrap_no_flag", v, 16'h0000);

        // 6: GPIO rising edge interrupt (feature-dependent)
        bus_wr(16'hFF02, 16'h0008);
        bus_rd(16'hFF02, v);  chk("gie_bit", v, GPIO_IRQ ? 16'h0008 : 16'h0000);
        gpio_in = 16'h5A3C;
        step(); step();
        bus_rd(16'hFF06, v);  chk("gpio_stat_cycle2", v, 16'h0000);
        bus_rd(16'hFF06, v);  chk("gpio_stat_cycle3", v, GPIO_IRQ ? 16'h0002 : 16'h0000);
        chk("gpio_int_pulse", 16'(int_vld), GPIO_IRQ ? 16'h0001 : 16'h0000);
        bus_wr(16'hFF06, 16'h0003);
        bus_wr(16'hFF02, 16'h0000);

        // Reset mid-operation: pending pulse dropped, RAM write not masked
        bus_wr(16'hFF00, 16'h3C3C);
        int_rdy = 1'b0;
        bus_wr(16'hFF04, 16'h0003);
        bus_wr(16'hFF05, 16'h0003);
        bus_wr(16'hFF03, 16'h0000);
        bus_wr(16'hFF02, 16'h0007);
        bus_wr(16'hFF02, 16'h0006);
        base = pulse_cnt;
        int_rdy = 1'b1;
        rst = 1'b1; d_addr = 16'h0020; d_din = 16'hBEEF; d_we = 1'b1; #1;
        chk("rst_ram_we_not_masked", 16'(ram_we), 16'h0001);
        step();
        rst = 1'b0; d_we = 1'b0;
        chk("rst_mid_int_vld", 16'(int_vld), 16'h0000);
        chk("rst_mid_gpio_out", gpio_out, 16'h0000);
        bus_rd(16'hFF02, v);  chk("rst_mid_ctrl", v, 16'h0000);
        bus_rd(16'hFF06, v);  chk("rst_mid_stat", v, 16'h0000);
        bus_rd(16'h0020, v);  chk("rst_mid_ram_write", v, 16'hBEEF);
        chk("rst_mid_pulse_dropped", 16'(pulse_cnt - base), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
